// File: rtl/wallace_mult_pipe.sv
// Pipelined Wallace-tree multiplier: Baugh-Wooley partial products, 3:2 carry-save
// layers spread over STAGES registers, final carry-propagate add in the last stage.
module wallace_mult_pipe #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 3
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               Clear,
  input  logic               Run,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   MUR,
  input  logic [WIDTH-1:0]   MUD,
  input  logic               Signed,
  output logic [2*WIDTH-1:0] result,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               busy
);

  localparam int PW = 2 * WIDTH;
  localparam int R  = WIDTH;

  typedef logic [R-1:0][PW-1:0] rows_t;

  function automatic int num_layers(input int rows);
    int n;
    int l;
    n = rows;
    l = 0;
    while (n > 2) begin
      n = 2 * (n / 3) + n % 3;
      l++;
    end
    return l;
  endfunction

  localparam int NL = num_layers(R);

  // Row i is MUD weighted by MUR[i]; signed mode inverts the cross terms that
  // touch exactly one operand MSB.
  function automatic rows_t gen_pp(input logic [WIDTH-1:0] mur,
                                   input logic [WIDTH-1:0] mud,
                                   input logic             sgn);
    rows_t pp;
    logic  t;
    pp = '0;
    for (int i = 0; i < WIDTH; i++) begin
      for (int j = 0; j < WIDTH; j++) begin
        t = mur[i] & mud[j];
        if (sgn && ((i == WIDTH-1) != (j == WIDTH-1))) t = ~t;
        pp[i][i+j] = t;
      end
    end
    return pp;
  endfunction

  // Live rows always sit at the low indices, so a fixed grouping works for every layer.
  function automatic rows_t csa_layer(input rows_t r_in);
    rows_t         r_out;
    logic [PW-1:0] a, b, c;
    r_out = '0;
    for (int g = 0; g < R/3; g++) begin
      a = r_in[3*g];
      b = r_in[3*g+1];
      c = r_in[3*g+2];
      r_out[2*g]   = a ^ b ^ c;
      r_out[2*g+1] = ((a & b) | (a & c) | (b & c)) << 1;
    end
    for (int j = 0; j < R%3; j++) r_out[2*(R/3)+j] = r_in[3*(R/3)+j];
    return r_out;
  endfunction

  logic              stall;
  logic              accept;
  logic [STAGES-1:0] valid_q, valid_d;
  logic [PW-1:0]     result_q, result_d;
  logic [PW-1:0]     cpa_sum;
  logic [PW-1:0]     bw_const;
  rows_t             stage_in  [STAGES];
  rows_t             stage_out [STAGES];
  logic              sgn_at    [STAGES];

  assign stall     = valid_q[STAGES-1] & ~out_ready;
  assign in_ready  = ~stall;
  assign accept    = Run & ~stall & ~Clear;
  assign out_valid = valid_q[STAGES-1];
  assign busy      = |valid_q;
  assign result    = result_q;

  assign stage_in[0] = gen_pp(MUR, MUD, Signed);
  assign sgn_at[0]   = Signed;

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    localparam int L0 = s * NL / STAGES;
    localparam int L1 = (s + 1) * NL / STAGES;
    rows_t chain [L1-L0+1];

    assign chain[0] = stage_in[s];
    for (genvar l = 0; l < L1 - L0; l++) begin : g_layer
      assign chain[l+1] = csa_layer(chain[l]);
    end
    assign stage_out[s] = chain[L1-L0];

    if (s < STAGES-1) begin : g_reg
      rows_t rows_q, rows_d;
      logic  sgn_q, sgn_d;

      always_comb begin
        rows_d = rows_q;
        sgn_d  = sgn_q;
        if (!stall) begin
          rows_d = stage_out[s];
          sgn_d  = sgn_at[s];
        end
      end

      always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
          rows_q <= '0;
          sgn_q  <= 1'b0;
        end else begin
          rows_q <= rows_d;
          sgn_q  <= sgn_d;
        end
      end

      assign stage_in[s+1] = rows_q;
      assign sgn_at[s+1]   = sgn_q;
    end
  end

  // Baugh-Wooley constants are folded into the final adder.
  assign bw_const = sgn_at[STAGES-1] ? ((PW'(1) << WIDTH) | (PW'(1) << (PW-1))) : '0;

  // Rows above index 1 are structurally zero after the last layer and fold away.
  always_comb begin
    cpa_sum = bw_const;
    for (int r = 0; r < R; r++) cpa_sum = cpa_sum + stage_out[STAGES-1][r];
  end

  always_comb begin
    valid_d  = valid_q;
    result_d = result_q;
    if (Clear) begin
      valid_d = '0;
    end else if (!stall) begin
      valid_d = (valid_q << 1) | STAGES'(accept);
    end
    if (!stall) result_d = cpa_sum;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      valid_q  <= '0;
      result_q <= '0;
    end else begin
      valid_q  <= valid_d;
      result_q <= result_d;
    end
  end

endmodule
